// File: rtl/coherence_bus_control_if.sv
// rtl/coherence_bus_control_if.sv - cache-side and RAM-side signal bundle for the coherence bus controller
interface coherence_bus_control_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    // per-CPU cache requests and coherence responses
    logic [CPUS-1:0]        iREN;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*WORD_W-1:0] iaddr;
    logic [CPUS*WORD_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        ccwrite;
    logic [CPUS-1:0]        cctrans;

    // per-CPU stalls, load data and snoop requests
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS*WORD_W-1:0] dload;
    logic [CPUS-1:0]        ccwait;
    logic [CPUS-1:0]        ccinv;
    logic [CPUS*WORD_W-1:0] ccsnoopaddr;

    // single-ported RAM; ramstate encoding FREE=0 BUSY=1 ACCESS=2 ERROR=3
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;

    // controller view
    modport master (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans,
        input  ramload, ramstate,
        output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    // caches and RAM view
    modport slave (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans,
        output ramload, ramstate,
        input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_control.sv
// rtl/coherence_bus_control.sv - dual-CPU MSI coherence bus controller; CC_STATS_EN adds c2c/inv counters
module coherence_bus_control #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    coherence_bus_control_if.master  bus
`ifdef CC_STATS_EN
    ,
    output logic [31:0]              c2c_count,
    output logic [31:0]              inv_count
`endif
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_RAMRD, S_IFETCH, S_SNOOP, S_C2C} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_req;
    logic              r_grant;
    logic              w_pick;
    logic              w_other;
    logic [CPUS-1:0]   w_any;
    logic              w_access;
    int                w_req_i;
    int                w_oth_i;
    logic [WORD_W-1:0] w_daddr_req;
    logic [WORD_W-1:0] w_iaddr_req;
    logic [WORD_W-1:0] w_dstore_req;
    logic [WORD_W-1:0] w_dstore_oth;

    assign w_any        = bus.iREN | bus.dREN | bus.dWEN;
    assign w_access     = (bus.ramstate == RAM_ACCESS);
    assign w_other      = (CPUS == 2) ? ~r_req : r_req;
    assign w_req_i      = int'(r_req);
    assign w_oth_i      = int'(w_other);
    assign w_daddr_req  = bus.daddr[w_req_i*WORD_W +: WORD_W];
    assign w_iaddr_req  = bus.iaddr[w_req_i*WORD_W +: WORD_W];
    assign w_dstore_req = bus.dstore[w_req_i*WORD_W +: WORD_W];
    assign w_dstore_oth = bus.dstore[w_oth_i*WORD_W +: WORD_W];

    // round-robin pick: on a tie, the CPU not granted last wins
    always_comb begin
        w_pick = 1'b0;
        if (CPUS == 2) begin
            if (w_any[0] && w_any[CPUS-1]) w_pick = ~r_grant;
            else                           w_pick = ~w_any[0];
        end
    end

    // state, requester and last-grant registers; requester/grant latch when leaving IDLE
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next != S_IDLE) begin
                r_req   <= w_pick;
                r_grant <= w_pick;
            end
        end
    end

    // next state: a dropped request aborts, except a C2C RAM write which always completes
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (|w_any) begin
                    if (bus.dWEN[w_pick])      w_next = S_WB;
                    else if (bus.dREN[w_pick]) w_next = (bus.cctrans[w_pick] && CPUS == 2) ? S_SNOOP : S_RAMRD;
                    else                       w_next = S_IFETCH;
                end
            end
            S_WB:     if (!bus.dWEN[r_req] || w_access) w_next = S_IDLE;
            S_RAMRD:  if (!bus.dREN[r_req] || w_access) w_next = S_IDLE;
            S_IFETCH: if (!bus.iREN[r_req] || w_access) w_next = S_IDLE;
            S_SNOOP: begin
                if (!bus.dREN[r_req])          w_next = S_IDLE;
                else if (bus.cctrans[w_other]) w_next = bus.ccwrite[w_other] ? S_C2C : S_RAMRD;
            end
            S_C2C:    if (w_access) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // outputs: every wait stays high unless this state acknowledges it
    always_comb begin
        bus.iwait       = '1;
        bus.dwait       = '1;
        bus.iload       = '0;
        bus.dload       = '0;
        bus.ccwait      = '0;
        bus.ccinv       = '0;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        case (r_state)
            S_WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = w_daddr_req;
                bus.ramstore = w_dstore_req;
                if (w_access && bus.dWEN[r_req]) bus.dwait[r_req] = 1'b0;
            end
            S_RAMRD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = w_daddr_req;
                if (w_access && bus.dREN[r_req]) begin
                    bus.dload[w_req_i*WORD_W +: WORD_W] = bus.ramload;
                    bus.dwait[r_req]                    = 1'b0;
                end
            end
            S_IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = w_iaddr_req;
                if (w_access && bus.iREN[r_req]) begin
                    bus.iload[w_req_i*WORD_W +: WORD_W] = bus.ramload;
                    bus.iwait[r_req]                    = 1'b0;
                end
            end
            S_SNOOP: begin
                bus.ccwait[w_other]                       = 1'b1;
                bus.ccsnoopaddr[w_oth_i*WORD_W +: WORD_W] = w_daddr_req;
                bus.ccinv[w_other]                        = bus.ccwrite[r_req];
            end
            S_C2C: begin
                bus.ccwait[w_other]                 = 1'b1;
                bus.dload[w_req_i*WORD_W +: WORD_W] = w_dstore_oth;
                bus.ramWEN                          = 1'b1;
                bus.ramaddr                         = w_daddr_req;
                bus.ramstore                        = w_dstore_oth;
                if (w_access) begin
                    bus.dwait[r_req]   = 1'b0;
                    bus.dwait[w_other] = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef CC_STATS_EN
    logic [31:0] r_c2c_count;
    logic [31:0] r_inv_count;

    // count completed cache-to-cache transfers and snoops that left with an invalidate
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_c2c_count <= '0;
            r_inv_count <= '0;
        end else begin
            if (r_state == S_C2C && w_access) r_c2c_count <= r_c2c_count + 32'd1;
            if (r_state == S_SNOOP && w_next != S_SNOOP && bus.ccwrite[r_req])
                r_inv_count <= r_inv_count + 32'd1;
        end
    end

    assign c2c_count = r_c2c_count;
    assign inv_count = r_inv_count;
`endif
endmodule

// File: tb/tb_coherence_bus_control.sv
// tb/tb_coherence_bus_control.sv - vector table plus scoreboard bench for coherence_bus_control
module tb_coherence_bus_control;
    localparam int CPUS = 2;
    localparam int W    = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam int K_I = 0, K_R = 1, K_W = 2;

    typedef struct {
        int          cpu;
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          cpu;
        logic [31:0] val;
    } sb_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    coherence_bus_control_if #(.CPUS(CPUS), .WORD_W(W)) bus();

`ifdef CC_STATS_EN
    logic [31:0] c2c_count;
    logic [31:0] inv_count;
`endif

    coherence_bus_control #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.master)
`ifdef CC_STATS_EN
        ,
        .c2c_count (c2c_count),
        .inv_count (inv_count)
`endif
    );

    logic [1:0]  iren, dren, dwen, ccw, cct;
    logic [31:0] iaddr_a [2];
    logic [31:0] daddr_a [2];
    logic [31:0] dstore_a [2];

    assign bus.iREN    = iren;
    assign bus.dREN    = dren;
    assign bus.dWEN    = dwen;
    assign bus.ccwrite = ccw;
    assign bus.cctrans = cct;
    assign bus.iaddr   = {iaddr_a[1], iaddr_a[0]};
    assign bus.daddr   = {daddr_a[1], daddr_a[0]};
    assign bus.dstore  = {dstore_a[1], dstore_a[0]};

    function automatic logic [31:0] init_val(input logic [7:0] i);
        if (i == 8'h40) return 32'hDEADBEEF;
        return {8'hA5, i, 8'h3C, ~i};
    endfunction

    // RAM model: latency 'lat' cycles of BUSY before ACCESS, or a forced state
    logic [31:0] mem [256];
    bit   [255:0] wr_v;
    int          lat      = 0;
    int          cnt      = 0;
    bit          force_en = 1'b0;
    logic [1:0]  force_st = FREE;

    always @(posedge CLK) begin
        if (bus.ramREN || bus.ramWEN) cnt <= cnt + 1;
        else                          cnt <= 0;
        if (bus.ramWEN && bus.ramstate == ACCESS) begin
            mem[bus.ramaddr[9:2]]  <= bus.ramstore;
            wr_v[bus.ramaddr[9:2]] <= 1'b1;
        end
    end

    always_comb begin
        if (force_en)                      bus.ramstate = force_st;
        else if (bus.ramREN || bus.ramWEN) bus.ramstate = (cnt >= lat) ? ACCESS : BUSY;
        else                               bus.ramstate = FREE;
        bus.ramload = wr_v[bus.ramaddr[9:2]] ? mem[bus.ramaddr[9:2]] : init_val(bus.ramaddr[9:2]);
    end

    logic [31:0] shadow [256];
    sb_t         sb [$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=no-ack exp=ack", name);
    endtask

    function automatic logic [31:0] wsel(input logic [63:0] v, input int c);
        return v[c*32 +: 32];
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_dack(input int cpu, input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge CLK);
            if (bus.dwait[cpu] == 1'b0) ok = 1'b1;
            else begin
                n++;
                next_cycle();
            end
        end
        if (!ok) fail(name);
    endtask

    task automatic do_txn(input vec_t v, input string name);
        sb_t         e, g;
        int          n;
        bit          done, other_ok, hit;
        logic [31:0] got;
        lat   = v.lat;
        e.cpu = v.cpu;
        e.val = (v.kind == K_W) ? v.data : v.exp;
        sb.push_back(e);
        case (v.kind)
            K_I:     begin iaddr_a[v.cpu] = v.addr; iren[v.cpu] = 1'b1; end
            K_R:     begin daddr_a[v.cpu] = v.addr; dren[v.cpu] = 1'b1; end
            default: begin daddr_a[v.cpu] = v.addr; dstore_a[v.cpu] = v.data; dwen[v.cpu] = 1'b1; end
        endcase
        n = 0; done = 1'b0; other_ok = 1'b1;
        while (!done && n < 40) begin
            @(negedge CLK);
            if (bus.iwait[1-v.cpu] !== 1'b1 || bus.dwait[1-v.cpu] !== 1'b1) other_ok = 1'b0;
            hit = (v.kind == K_I) ? (bus.iwait[v.cpu] == 1'b0) : (bus.dwait[v.cpu] == 1'b0);
            if (hit) begin
                g   = sb.pop_front();
                got = (v.kind == K_I) ? wsel(bus.iload, v.cpu) :
                      (v.kind == K_R) ? wsel(bus.dload, v.cpu) : bus.ramstore;
                check({name, "_data"}, got, g.val);
                check({name, "_addr"}, bus.ramaddr, v.addr);
                check({name, "_lat"}, n, v.lat + 1);
                done = 1'b1;
            end
            n++;
            next_cycle();
        end
        if (!done) begin
            fail({name, "_timeout"});
            sb.delete();
        end
        check({name, "_other_wait"}, other_ok, 1'b1);
        iren[v.cpu] = 1'b0;
        dren[v.cpu] = 1'b0;
        dwen[v.cpu] = 1'b0;
        if (v.kind == K_W) shadow[v.addr[9:2]] = v.data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        vec_t rb;
        sb_t  e, g;
        bit   ok, held;
        bit   ackd [2];
        int   acks0, n;

        iren = '0; dren = '0; dwen = '0; ccw = '0; cct = '0;
        for (int c = 0; c < 2; c++) begin
            iaddr_a[c] = '0; daddr_a[c] = '0; dstore_a[c] = '0;
        end
        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));

        vecs[0] = '{0, K_I, 32'h100, 32'h0,        2, 32'hDEADBEEF};
        vecs[1] = '{1, K_W, 32'h040, 32'h11112222, 1, 32'h0};
        vecs[2] = '{0, K_R, 32'h040, 32'h0,        0, 32'h11112222};
        vecs[3] = '{1, K_I, 32'h004, 32'h0,        1, init_val(8'h01)};
        vecs[4] = '{0, K_W, 32'h080, 32'hA5A5A5A5, 3, 32'h0};
        vecs[5] = '{1, K_R, 32'h080, 32'h0,        1, 32'hA5A5A5A5};

        // reset values
        repeat (2) @(negedge CLK);
        check("rst_iwait", bus.iwait, 2'b11);
        check("rst_dwait", bus.dwait, 2'b11);
        check("rst_cc", {bus.ccwait, bus.ccinv}, 4'b0);
        check("rst_snoopaddr", bus.ccsnoopaddr, 64'h0);
        check("rst_ram", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}, 66'h0);
        check("rst_loads", bus.iload | bus.dload, 64'h0);
`ifdef CC_STATS_EN
        check("rst_stats", {c2c_count, inv_count}, 64'h0);
`endif
        next_cycle();
        nRST = 1'b1;
        next_cycle();

        // single-requester vectors
        for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // same-cycle contest, then CPU0 re-requests against waiting CPU1
        lat = 1;
        e = '{0, shadow[0]}; sb.push_back(e);
        e = '{1, shadow[1]}; sb.push_back(e);
        e = '{0, shadow[2]}; sb.push_back(e);
        iaddr_a[0] = 32'h0; iaddr_a[1] = 32'h4; iren = 2'b11;
        acks0 = 0; n = 0;
        while (sb.size() > 0 && n < 60) begin
            ackd[0] = 1'b0; ackd[1] = 1'b0;
            @(negedge CLK);
            for (int c = 0; c < 2; c++) begin
                if (bus.iwait[c] == 1'b0) begin
                    ackd[c] = 1'b1;
                    if (sb.size() == 0) fail("rr_extra_ack");
                    else begin
                        g = sb.pop_front();
                        check("rr_cpu", c, g.cpu);
                        check("rr_data", wsel(bus.iload, c), g.val);
                        check("rr_loser_wait", bus.iwait[1-c], 1'b1);
                    end
                end
            end
            n++;
            next_cycle();
            if (ackd[0]) begin
                acks0++;
                if (acks0 == 1) iaddr_a[0] = 32'h8;
                else            iren[0] = 1'b0;
            end
            if (ackd[1]) iren[1] = 1'b0;
        end
        if (sb.size() > 0) begin
            fail("rr_timeout");
            sb.delete();
        end
        iren = '0;

        // CPU1 BusRdX snoop, CPU0 answers without the line Modified
        lat = 1;
        daddr_a[1] = 32'h200; dren[1] = 1'b1; cct[1] = 1'b1; ccw[1] = 1'b1;
        e = '{1, shadow[8'h80]}; sb.push_back(e);
        next_cycle();
        @(negedge CLK);
        check("snp_ccwait", bus.ccwait, 2'b01);
        check("snp_ccinv", bus.ccinv, 2'b01);
        check("snp_addr", wsel(bus.ccsnoopaddr, 0), 32'h200);
        check("snp_noram", {bus.ramREN, bus.ramWEN}, 2'b00);
        next_cycle();
        cct[0] = 1'b1; ccw[0] = 1'b0;
        @(negedge CLK);
        check("snp_hold", {bus.ccwait, bus.dwait}, 4'b0111);
        next_cycle();
        cct[0] = 1'b0;
        wait_dack(1, "snp_rd_timeout", ok);
        if (ok) begin
            g = sb.pop_front();
            check("snp_rd_data", wsel(bus.dload, 1), g.val);
            check("snp_rd_ram", {bus.ramREN, bus.ramaddr, bus.ccwait}, {1'b1, 32'h200, 2'b00});
        end else sb.delete();
        next_cycle();
        dren[1] = 1'b0; cct[1] = 1'b0; ccw[1] = 1'b0;
`ifdef CC_STATS_EN
        check("stat_inv1", inv_count, 32'd1);
`endif

        // CPU0 read miss served cache-to-cache by CPU1
        lat = 2;
        daddr_a[0] = 32'h300; dren[0] = 1'b1; cct[0] = 1'b1;
        next_cycle();
        @(negedge CLK);
        check("c2c_snoop", {bus.ccwait, bus.ccinv, wsel(bus.ccsnoopaddr, 1)}, {2'b10, 2'b00, 32'h300});
        next_cycle();
        cct[1] = 1'b1; ccw[1] = 1'b1; dstore_a[1] = 32'hCAFE0001;
        next_cycle();
        cct[1] = 1'b0;
        @(negedge CLK);
        check("c2c_ram", {bus.ramWEN, bus.ramaddr, bus.ramstore}, {1'b1, 32'h300, 32'hCAFE0001});
        check("c2c_dload", wsel(bus.dload, 0), 32'hCAFE0001);
        check("c2c_wait_pre", {bus.ccwait, bus.dwait}, 4'b1011);
        next_cycle();
        wait_dack(0, "c2c_timeout", ok);
        if (ok) check("c2c_both_ack", bus.dwait, 2'b00);
        next_cycle();
        dren[0] = 1'b0; cct[0] = 1'b0; ccw[1] = 1'b0;
        shadow[8'hC0] = 32'hCAFE0001;
`ifdef CC_STATS_EN
        check("stat_c2c1", {c2c_count, inv_count}, {32'd1, 32'd1});
`endif
        rb = '{1, K_R, 32'h300, 32'h0, 1, shadow[8'hC0]};
        do_txn(rb, "c2c_readback");

        // write-back stalled by BUSY then ERROR, then completed
        daddr_a[0] = 32'h40; dstore_a[0] = 32'h12345678; dwen[0] = 1'b1;
        force_en = 1'b1; force_st = BUSY;
        next_cycle();
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) force_st = ERROR;
            @(negedge CLK);
            if (bus.dwait[0] !== 1'b1 || bus.ramWEN !== 1'b1) held = 1'b0;
            next_cycle();
        end
        check("busy_err_hold", held, 1'b1);
        force_st = ACCESS;
        @(negedge CLK);
        check("wb_ack", {bus.dwait[0], bus.ramaddr, bus.ramstore}, {1'b0, 32'h40, 32'h12345678});
        next_cycle();
        dwen[0] = 1'b0; force_en = 1'b0;
        shadow[8'h10] = 32'h12345678;

        // requester drops its read mid-transaction
        daddr_a[1] = 32'h40; dren[1] = 1'b1;
        force_en = 1'b1; force_st = BUSY;
        next_cycle();
        @(negedge CLK);
        check("drop_rd_active", bus.ramREN, 1'b1);
        next_cycle();
        dren[1] = 1'b0;
        @(negedge CLK);
        check("drop_no_ack", bus.dwait, 2'b11);
        next_cycle();
        @(negedge CLK);
        check("drop_idle", {bus.ramREN, bus.ramWEN, bus.dwait}, 4'b0011);
        next_cycle();
        force_en = 1'b0;
        rb = '{1, K_R, 32'h40, 32'h0, 0, shadow[8'h10]};
        do_txn(rb, "wb_readback");

        // reset pulse in the middle of a C2C
        daddr_a[0] = 32'h340; dren[0] = 1'b1; cct[0] = 1'b1;
        force_en = 1'b1; force_st = BUSY;
        next_cycle();
        next_cycle();
        cct[1] = 1'b1; ccw[1] = 1'b1; dstore_a[1] = 32'hBAD0C2C0;
        next_cycle();
        cct[1] = 1'b0;
        @(negedge CLK);
        check("rstc2c_pre", bus.ramWEN, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        check("rstc2c_waits", {bus.iwait, bus.dwait, bus.ccwait}, 6'b111100);
        check("rstc2c_ram", {bus.ramWEN, bus.ramaddr, bus.ramstore}, 65'h0);
        check("rstc2c_dload", bus.dload, 64'h0);
`ifdef CC_STATS_EN
        check("rstc2c_stats", {c2c_count, inv_count}, 64'h0);
`endif
        dren = '0; cct = '0; ccw = '0; force_en = 1'b0;
        next_cycle();
        nRST = 1'b1;
        next_cycle();
        rb = '{0, K_R, 32'h340, 32'h0, 1, shadow[8'hD0]};
        do_txn(rb, "rstc2c_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
